serial_tx: RTL and testbench

- Parallel-to-serial framed transmitter: accepts one DATA_W-bit word via valid/ready and drives it onto a single line.
- Frame order: start bit, data LSB first, optional even-parity bit, stop bit.
- Each bit is held for CLKS_PER_BIT clock cycles.
- Counterpart of the team's serial receiver; built as a Yosys synthesis benchmark mapped onto the in-house CMOS cell set (BUF/NOT/NAND/NOR/DFF/DFFSR), so no arithmetic beyond counters.

---
 rtl/serial_tx.sv | 148 ++++++++++++++
 tb/tb_serial_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial framed transmitter.
// Takes one DATA_W-bit word over a valid/ready handshake and sends it on txd as:
// start bit (0), data LSB first, optional even-parity bit, stop bit (1).
// Every serial bit lasts CLKS_PER_BIT cycles of C.
// Ports:
//   C          clock, rising edge
//   R          asynchronous active-high reset
//   tx_data    word to send, sampled only when it is accepted
//   tx_valid   tx_data is valid
//   tx_ready   block can accept a word (registered)
//   txd        serial line, idles high (registered)
//   busy       frame in progress (registered)
//   frame_done one-cycle pulse in the first idle cycle after the stop bit (registered)
module serial_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic              C,
  input  logic              R,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nx;
  logic              par_bit;
  logic [BAUD_W-1:0] baud;
  logic [BIT_W-1:0]  bit_cnt;
  logic              bit_end;

  // Next data bit is the low bit after the shift; zero-fill keeps DATA_W=1 legal.
  assign shreg_nx = shreg >> 1;
  // Last cycle of the current serial bit period.
  assign bit_end  = (baud == BAUD_LAST);

  // Frame sequencer; txd is loaded with the level of the upcoming bit so it is registered.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state      <= IDLE;
      shreg      <= '0;
      par_bit    <= 1'b0;
      baud       <= '0;
      bit_cnt    <= '0;
      txd        <= 1'b1;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          txd      <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          baud     <= '0;
          bit_cnt  <= '0;
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
            par_bit  <= ^tx_data;
            state    <= START;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            txd     <= shreg[0];
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud  <= '0;
            shreg <= shreg_nx;
            if (bit_cnt == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                txd   <= par_bit;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              txd     <= shreg_nx[0];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            baud  <= '0;
            state <= STOP;
            txd   <= 1'b1;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud       <= '0;
            state      <= IDLE;
            txd        <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          txd      <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          baud     <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three instances (defaults, parity on, one clock per bit)
// checked by hand-written frame tables, directed corner sequences, and a
// frame-level reference model running under random stimulus.
module tb_serial_tx;

  logic       C = 1'b0;
  logic       R = 1'b0;
  logic [7:0] tx_data  [3];
  logic       tx_valid [3];
  logic       tx_ready [3];
  logic       txd      [3];
  logic       busy     [3];
  logic       frame_done [3];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_def (
    .C(C), .R(R), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .txd(txd[0]), .busy(busy[0]), .frame_done(frame_done[0]));

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_par (
    .C(C), .R(R), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .txd(txd[1]), .busy(busy[1]), .frame_done(frame_done[1]));

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_fast (
    .C(C), .R(R), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .txd(txd[2]), .busy(busy[2]), .frame_done(frame_done[2]));

  always #5 C = ~C;

  function automatic int cpb_of(int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int par_of(int i);
    return (i == 1) ? 1 : 0;
  endfunction

  // Frame length in cycles: start + 8 data + optional parity + stop, each cpb long.
  function automatic int flen(int i);
    return (10 + par_of(i)) * cpb_of(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pos = cycle offset inside the current frame, -1 when idle,
  // flen when in the frame_done cycle (which is also an idle cycle).
  int         pos   [3] = '{-1, -1, -1};
  logic [7:0] mdata [3];

  function automatic bit model_ready(int i);
    return (pos[i] < 0) || (pos[i] == flen(i));
  endfunction

  // Expected {txd, tx_ready, busy, frame_done} for the current cycle.
  function automatic logic [3:0] exp_of(int i);
    int  b;
    logic v;
    if (pos[i] < 0)        return 4'b1100;
    if (pos[i] == flen(i)) return 4'b1101;
    b = pos[i] / cpb_of(i);
    if (b == 0)                          v = 1'b0;
    else if (b <= 8)                     v = mdata[i][b-1];
    else if (b == 9 && par_of(i) == 1)   v = ^mdata[i];
    else                                 v = 1'b1;
    return {v, 1'b0, 1'b1, 1'b0};
  endfunction

  always @(posedge C or posedge R) begin
    for (int i = 0; i < 3; i++) begin
      if (R) begin
        pos[i] <= -1;
      end else if (model_ready(i) && tx_valid[i]) begin
        mdata[i] <= tx_data[i];
        pos[i]   <= 0;
      end else if (pos[i] == flen(i)) begin
        pos[i] <= -1;
      end else if (pos[i] >= 0) begin
        pos[i] <= pos[i] + 1;
      end
    end
  end

  always @(negedge C) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++)
        check($sformatf("model_u%0d", i),
              32'({txd[i], tx_ready[i], busy[i], frame_done[i]}), 32'(exp_of(i)));
    end
  end

  typedef struct {
    int         inst;
    logic [7:0] data;
    string      seq;       // transmitted bit levels, first bit leftmost
    int         done_cyc;  // cycle of the frame_done pulse, acceptance is cycle 0
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v);
    int i, cpb, k;
    logic et;
    i   = v.inst;
    cpb = cpb_of(i);
    @(negedge C);
    tx_data[i]  = v.data;
    tx_valid[i] = 1'b1;
    @(negedge C);
    tx_valid[i] = 1'b0;
    for (int c = 1; c <= v.done_cyc; c++) begin
      if (c > 1) @(negedge C);
      k  = (c - 1) / cpb;
      et = (k < v.seq.len()) ? (v.seq.getc(k) == "1") : 1'b1;
      check($sformatf("vec%0h_txd_c%0d", v.data, c), 32'(txd[i]), 32'(et));
      check($sformatf("vec%0h_done_c%0d", v.data, c), 32'(frame_done[i]), 32'(c == v.done_cyc));
      if (c == v.done_cyc) check($sformatf("vec%0h_ready", v.data), 32'(tx_ready[i]), 32'd1);
    end
    repeat (3) @(negedge C);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      tx_data[i]  = 8'h00;
      tx_valid[i] = 1'b0;
    end
    vecs[0] = '{0, 8'hA5, "0101001011",  41};
    vecs[1] = '{1, 8'h07, "01110000011", 45};
    vecs[2] = '{2, 8'h81, "0100000011",  11};
    vecs[3] = '{1, 8'hA5, "01010010101", 45};
    vecs[4] = '{0, 8'h00, "0000000001",  41};
    vecs[5] = '{2, 8'h3C, "0001111001",  11};

    // Reset asserted between clock edges must show idle outputs at once.
    #1 R = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_u%0d", i),
            32'({txd[i], tx_ready[i], busy[i], frame_done[i]}), 32'(4'b1100));
    chk_en = 1'b1;
    repeat (2) @(negedge C);
    #1 R = 1'b0;

    for (int t = 0; t < 6; t++) run_vec(vecs[t]);

    // Back-to-back 0x00 then 0xFF with tx_valid held; data changes mid-frame.
    @(negedge C);
    tx_data[0]  = 8'h00;
    tx_valid[0] = 1'b1;
    @(negedge C);
    tx_data[0] = 8'hFF;
    for (int c = 1; c <= 90; c++) begin
      if (c > 1) @(negedge C);
      check($sformatf("b2b_txd_c%0d", c), 32'(txd[0]),
            32'(!((c >= 1 && c <= 36) || (c >= 42 && c <= 45))));
      check($sformatf("b2b_done_c%0d", c), 32'(frame_done[0]), 32'(c == 41 || c == 82));
      if (c == 42) begin
        tx_valid[0] = 1'b0;
        tx_data[0]  = 8'h12;
      end
    end

    // Busy-ignore: a word offered mid-frame is dropped, not queued.
    @(negedge C);
    tx_data[0]  = 8'h5A;
    tx_valid[0] = 1'b1;
    @(negedge C);
    tx_valid[0] = 1'b0;
    for (int c = 1; c <= 55; c++) begin
      string s;
      s = "0010110101";
      if (c > 1) @(negedge C);
      check($sformatf("ign_txd_c%0d", c), 32'(txd[0]),
            32'((c <= 40) ? (s.getc((c - 1) / 4) == "1") : 1'b1));
      check($sformatf("ign_busy_c%0d", c), 32'(busy[0]), 32'(c <= 40));
      if (c == 10) begin
        tx_data[0]  = 8'h3C;
        tx_valid[0] = 1'b1;
      end
      if (c == 11) tx_valid[0] = 1'b0;
    end

    // Reset during the data bits: line returns high immediately, nothing resumes.
    @(negedge C);
    tx_data[0]  = 8'h00;
    tx_valid[0] = 1'b1;
    @(negedge C);
    tx_valid[0] = 1'b0;
    repeat (9) @(negedge C);
    check("midrst_pre_txd", 32'(txd[0]), 32'd0);
    #1 R = 1'b1;
    #1;
    check("midrst_txd", 32'(txd[0]), 32'd1);
    check("midrst_ready", 32'(tx_ready[0]), 32'd1);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    @(negedge C);
    #1 R = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge C);
      check($sformatf("postrst_c%0d", c), 32'({txd[0], busy[0]}), 32'(2'b10));
    end

    // Random traffic, data churn and occasional resets against the model.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge C);
      #1;
      for (int i = 0; i < 3; i++) begin
        tx_valid[i] = ($urandom_range(0, 3) == 0);
        tx_data[i]  = 8'($urandom);
      end
      R = ($urandom_range(0, 299) == 0);
    end
    @(negedge C);
    #1;
    R = 1'b0;
    for (int i = 0; i < 3; i++) tx_valid[i] = 1'b0;
    repeat (60) @(negedge C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
